// File: rtl/msrv32_integer_file.sv
// Integer register file: 32 x XLEN registers with x0 tied to zero, registered
// read ports with same-cycle write-back bypass, and a pending-write scoreboard.
module msrv32_integer_file #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            ms_riscv32_mp_clk_in,
    input  logic            ms_riscv32_mp_rst_in,
    input  logic [4:0]      rs1_addr_in,
    input  logic [4:0]      rs2_addr_in,
    input  logic [4:0]      rd_addr_in,
    input  logic            wr_en_in,
    input  logic [XLEN-1:0] rd_in,
    input  logic            rd_issue_in,
    input  logic [4:0]      rd_issue_addr_in,
    output logic [XLEN-1:0] rs1_out,
    output logic [XLEN-1:0] rs2_out,
    output logic            stall_out
);

    logic [XLEN-1:0]  regs_q [NREGS];
    logic [XLEN-1:0]  regs_d [NREGS];
    logic [XLEN-1:0]  rs1_q;
    logic [XLEN-1:0]  rs1_d;
    logic [XLEN-1:0]  rs2_q;
    logic [XLEN-1:0]  rs2_d;
    logic [NREGS-1:0] pending_q;
    logic [NREGS-1:0] pending_d;
    logic             p1_s;
    logic             p2_s;

    // Architectural register update; x0 is forced back to zero every cycle.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = regs_q[i];
        end
        if (wr_en_in && (rd_addr_in != 5'd0)) begin
            regs_d[rd_addr_in] = rd_in;
        end else begin
            regs_d[0] = {XLEN{1'b0}};
        end
        regs_d[0] = {XLEN{1'b0}};
    end

    // Read operand selection, with the write-back value bypassed on an index match.
    always_comb begin
        rs1_d = {XLEN{1'b0}};
        rs2_d = {XLEN{1'b0}};
        if (rs1_addr_in == 5'd0) begin
            rs1_d = {XLEN{1'b0}};
        end else if (wr_en_in && (rd_addr_in == rs1_addr_in)) begin
            rs1_d = rd_in;
        end else begin
            rs1_d = regs_q[rs1_addr_in];
        end
        if (rs2_addr_in == 5'd0) begin
            rs2_d = {XLEN{1'b0}};
        end else if (wr_en_in && (rd_addr_in == rs2_addr_in)) begin
            rs2_d = rd_in;
        end else begin
            rs2_d = regs_q[rs2_addr_in];
        end
    end

    // Scoreboard: clear on write-back first so that a same-index issue wins.
    always_comb begin
        pending_d = pending_q;
        if (wr_en_in) begin
            pending_d[rd_addr_in] = 1'b0;
        end else begin
            pending_d = pending_q;
        end
        if (rd_issue_in && (rd_issue_addr_in != 5'd0)) begin
            pending_d[rd_issue_addr_in] = 1'b1;
        end else begin
            pending_d[0] = 1'b0;
        end
        pending_d[0] = 1'b0;
    end

    // Hazard flag; a same-cycle write-back to the source resolves it via bypass.
    always_comb begin
        p1_s      = pending_q[rs1_addr_in] & ~(wr_en_in & (rd_addr_in == rs1_addr_in));
        p2_s      = pending_q[rs2_addr_in] & ~(wr_en_in & (rd_addr_in == rs2_addr_in));
        stall_out = p1_s | p2_s;
    end

    // State registers with synchronous active-low reset taking priority.
    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_in) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= {XLEN{1'b0}};
            end
            rs1_q     <= {XLEN{1'b0}};
            rs2_q     <= {XLEN{1'b0}};
            pending_q <= {NREGS{1'b0}};
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            pending_q <= pending_d;
        end
    end

    assign rs1_out = rs1_q;
    assign rs2_out = rs2_q;

endmodule

// File: doc/msrv32_integer_file.md
Name: msrv32_integer_file

Overview:
- Integer register file that consumes the write-back path. It takes the selected write-back value (rd_in, driven by the wb mux output) and the destination index, and sources the rs1/rs2 operands that feed the ALU and the immediate adder on the next stage.
- Holds 32 x 32-bit registers; x0 is hardwired to zero.
- Registered read ports, with write-to-read bypass in the same cycle.
- Includes a pending-write scoreboard that flags read-after-write hazards against in-flight destinations, e.g. loads.

Parameters:
- XLEN, 32, register and data width.
- NREGS, 32, number of architectural registers (index width 5; fixed, not to be changed independently).

Ports:
- ms_riscv32_mp_clk_in  input  1  core clock; all state updates on the rising edge.
- ms_riscv32_mp_rst_in  input  1  synchronous reset, active-low.
- rs1_addr_in  input  5  source register 1 index.
- rs2_addr_in  input  5  source register 2 index.
- rd_addr_in  input  5  write-back destination index.
- wr_en_in  input  1  write-back enable.
- rd_in  input  XLEN  write-back data (wb mux output).
- rd_issue_in  input  1  an instruction writing rd_issue_addr_in has been issued and is not yet written back.
- rd_issue_addr_in  input  5  destination index of the issued instruction.
- rs1_out  output  XLEN  registered rs1 operand.
- rs2_out  output  XLEN  registered rs2 operand.
- stall_out  output  1  combinational hazard flag for the current rs1/rs2 addresses.

Behaviour:
- Reset: when ms_riscv32_mp_rst_in is 0 at a rising edge, the following all go to 0:
  - every register x0..x31;
  - rs1_out and rs2_out;
  - all 32 scoreboard pending bits.
  - stall_out is therefore 0 the cycle after reset.
  - Reset has priority over writes, issues and reads in the same cycle, including reset asserted mid-operation.
- Write: at a rising edge with reset high, wr_en_in=1 and rd_addr_in!=0 sets reg[rd_addr_in] <= rd_in. Writes to x0 are discarded.
- Read latency is 1 cycle. At each rising edge (reset high):
  - rs1_out <= 0 if rs1_addr_in==0;
  - else rd_in if wr_en_in and rd_addr_in==rs1_addr_in (bypass);
  - else reg[rs1_addr_in].
  - rs2_out follows the same rule with rs2_addr_in.
  - Reads update every cycle regardless of stall_out.
- Scoreboard, one pending bit per register; bit 0 is permanently 0.
  - Set: rd_issue_in=1 and rd_issue_addr_in!=0 sets pending[rd_issue_addr_in].
  - Clear: wr_en_in=1 clears pending[rd_addr_in].
  - Same index set and cleared in the same edge: set wins (a newer writer is in flight).
  - Different indices set and cleared in the same edge: both take effect.
  - Issuing an already-pending index leaves it pending. There is no counter; a single outstanding writer per register is assumed by issue logic.
- stall_out is combinational and equals (P(rs1_addr_in) OR P(rs2_addr_in)), where:
  - P(a) = pending[a] AND NOT (wr_en_in AND rd_addr_in==a);
  - a same-cycle write-back to index a resolves the hazard through the bypass;
  - P(0)=0.
- Arithmetic and width: no arithmetic; all data paths are XLEN wide; indices are 5-bit and unsigned.

Test Plan:
- Reset then read x0..x31: assert rst_in=0 for 2 cycles, release, sweep rs1_addr_in 0..31 -> rs1_out=0x00000000 every cycle, stall_out=0.
- Write/read: write x5=0xA5A5A5A5 (wr_en=1, rd_addr=5); next cycle read rs1_addr=5, rs2_addr=5 -> one cycle later rs1_out=rs2_out=0xA5A5A5A5.
- x0 immunity: write rd_addr=0, rd_in=0xFFFFFFFF; read rs1_addr=0 in the same cycle and the next -> rs1_out=0 both times.
- Bypass: same cycle wr_en=1, rd_addr=7, rd_in=0x12345678, rs2_addr=7 (x7 previously 0x0) -> next edge rs2_out=0x12345678.
- Scoreboard:
  - issue rd_issue_addr=9; next cycle rs1_addr=9 -> stall_out=1;
  - drive wr_en=1, rd_addr=9, rd_in=0x98765432 -> stall_out=0 in that cycle, rs1_out=0x98765432 next edge, pending[9] cleared;
  - simultaneous issue and write-back to x9 -> stall_out=1 the following cycle.
- Reset mid-operation: pending[3]=1 and x3=0xBCDEF012, assert reset with wr_en=1 to x4 in the same cycle -> afterwards x3=x4=0, rs outputs 0, stall_out=0 for rs1_addr=3.
